// File: rtl/gf_mult_pkg.sv
// Shared types and GF(2^8) arithmetic helpers for the sequential multiplier.
// The GF_MULT_ACC_EN build option is handled in gf_mult_lane.
package gf_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] AES_POLY = 8'h1B;

  // Multiply by x modulo x^8 + poly.
  function automatic logic [7:0] xtime(input logic [7:0] x, input logic [7:0] poly);
    return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
  endfunction

  // One MSB-first Horner step: p*x + (bit ? a : 0).
  function automatic logic [7:0] gf_step(input logic [7:0] p, input logic [7:0] a,
                                         input logic b, input logic [7:0] poly);
    return xtime(p, poly) ^ (b ? a : 8'h00);
  endfunction

endpackage

// File: rtl/gf_mult_seq_if.sv
// Operand/result handshake bundle for gf_mult_seq. Both sides use valid/ready
// semantics: a transfer happens on a clock edge where valid and ready (yumi) are both high.
interface gf_mult_seq_if
  import gf_mult_pkg::*;
#(
  parameter int LANES = 4
);
  logic               v_i;
  logic               ready_o;
  logic [LANES*8-1:0] num_1_i;
  logic [LANES*8-1:0] num_2_i;
  logic               acc_clr_i;
  logic               v_o;
  logic               yumi_i;
  logic [LANES*8-1:0] result_o;
  state_e             dbg_state_o;

  modport master (
    output v_i, num_1_i, num_2_i, acc_clr_i, yumi_i,
    input  ready_o, v_o, result_o, dbg_state_o
  );

  modport slave (
    input  v_i, num_1_i, num_2_i, acc_clr_i, yumi_i,
    output ready_o, v_o, result_o, dbg_state_o
  );
endinterface

// File: rtl/gf_mult_lane.sv
// One byte lane: operand registers, partial product and B unrolled Horner steps.
// With GF_MULT_ACC_EN defined, the lane also XOR-accumulates consumed results.
module gf_mult_lane
  import gf_mult_pkg::*;
#(
  parameter int         B    = 1,
  parameter logic [7:0] POLY = AES_POLY
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic       step_i,
  input  logic       last_i,
  input  logic       take_i,
  input  logic       acc_clr_i,
  input  logic [7:0] num_1_i,
  input  logic [7:0] num_2_i,
  output logic [7:0] result_o
);

  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] p_q, p_d;
  logic [7:0] res_q, res_d;
  logic [7:0] p_next;
  logic [7:0] acc_val;

`ifdef GF_MULT_ACC_EN
  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (load_i && acc_clr_i) acc_d = 8'h00;
    else if (take_i)         acc_d = res_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) acc_q <= 8'h00;
    else         acc_q <= acc_d;
  end

  assign acc_val = acc_q;
`else
  logic unused_acc_ctl;
  assign unused_acc_ctl = acc_clr_i ^ take_i;
  assign acc_val        = 8'h00;
`endif

  always_comb begin
    p_next = p_q;
    for (int i = 0; i < B; i++) begin
      p_next = gf_step(p_next, a_q, b_q[7-i], POLY);
    end
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    p_d   = p_q;
    res_d = res_q;
    if (load_i) begin
      a_d = num_1_i;
      b_d = num_2_i;
      p_d = 8'h00;
    end else if (step_i) begin
      p_d = p_next;
      b_d = b_q << B;
      // Result register is loaded on the final step so it appears with v_o.
      if (last_i) res_d = acc_val ^ p_next;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      a_q   <= 8'h00;
      b_q   <= 8'h00;
      p_q   <= 8'h00;
      res_q <= 8'h00;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      p_q   <= p_d;
      res_q <= res_d;
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/gf_mult_seq.sv
// Multicycle multi-lane GF(2^8) multiplier: IDLE -> BUSY (8/B cycles) -> DONE.
// Optional XOR accumulation is enabled by defining GF_MULT_ACC_EN.
module gf_mult_seq
  import gf_mult_pkg::*;
#(
  parameter int         LANES          = 4,
  parameter int         BITS_PER_CYCLE = 1,
  parameter logic [7:0] POLY           = AES_POLY
) (
  input  logic clk_i,
  input  logic reset_i,
  gf_mult_seq_if.slave bus
);

  localparam int         LAST  = 8 / BITS_PER_CYCLE - 1;
  localparam logic [2:0] LAST3 = 3'(LAST);

  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 &&
      BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_bad_b
    $error("gf_mult_seq: BITS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic       ready_q, ready_d;
  logic       v_q, v_d;
  logic       accept, step, last, take;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ready_d = ready_q;
    v_d     = v_q;
    case (state_q)
      IDLE: if (bus.v_i) begin
        state_d = BUSY;
        count_d = 3'd0;
        ready_d = 1'b0;
      end
      BUSY: begin
        count_d = count_q + 3'd1;
        if (count_q == LAST3) begin
          state_d = DONE;
          v_d     = 1'b1;
        end
      end
      DONE: if (bus.yumi_i) begin
        state_d = IDLE;
        ready_d = 1'b1;
        v_d     = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      count_q <= 3'd0;
      ready_q <= 1'b1;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= ready_d;
      v_q     <= v_d;
    end
  end

  assign accept = (state_q == IDLE) && bus.v_i;
  assign step   = (state_q == BUSY);
  assign last   = step && (count_q == LAST3);
  assign take   = (state_q == DONE) && bus.yumi_i;

  logic [LANES*8-1:0] result_w;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    gf_mult_lane #(
      .B    (BITS_PER_CYCLE),
      .POLY (POLY)
    ) u_lane (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .load_i    (accept),
      .step_i    (step),
      .last_i    (last),
      .take_i    (take),
      .acc_clr_i (bus.acc_clr_i),
      .num_1_i   (bus.num_1_i[8*k +: 8]),
      .num_2_i   (bus.num_2_i[8*k +: 8]),
      .result_o  (result_w[8*k +: 8])
    );
  end

  assign bus.ready_o     = ready_q;
  assign bus.v_o         = v_q;
  assign bus.result_o    = result_w;
  assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_gf_mult_seq.sv
// Directed bench for gf_mult_seq: four 4-lane instances (B = 1, 2, 4, 8) driven in lock-step.
module tb_gf_mult_seq;
  import gf_mult_pkg::*;

  logic clk;
  logic rst;

  logic        v_i;
  logic [31:0] num_1;
  logic [31:0] num_2;
  logic        acc_clr;
  logic [3:0]  yumi;

  logic [3:0]  v_o_w;
  logic [3:0]  ready_w;
  logic [31:0] res_w [4];

  int n_chk;
  int n_pass;

`ifdef GF_MULT_ACC_EN
  logic [31:0] acc_m;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  gf_mult_seq_if #(.LANES(4)) if_b1 ();
  gf_mult_seq_if #(.LANES(4)) if_b2 ();
  gf_mult_seq_if #(.LANES(4)) if_b4 ();
  gf_mult_seq_if #(.LANES(4)) if_b8 ();

  assign if_b1.v_i = v_i; assign if_b1.num_1_i = num_1; assign if_b1.num_2_i = num_2;
  assign if_b2.v_i = v_i; assign if_b2.num_1_i = num_1; assign if_b2.num_2_i = num_2;
  assign if_b4.v_i = v_i; assign if_b4.num_1_i = num_1; assign if_b4.num_2_i = num_2;
  assign if_b8.v_i = v_i; assign if_b8.num_1_i = num_1; assign if_b8.num_2_i = num_2;
  assign if_b1.acc_clr_i = acc_clr; assign if_b2.acc_clr_i = acc_clr;
  assign if_b4.acc_clr_i = acc_clr; assign if_b8.acc_clr_i = acc_clr;
  assign if_b1.yumi_i = yumi[0]; assign if_b2.yumi_i = yumi[1];
  assign if_b4.yumi_i = yumi[2]; assign if_b8.yumi_i = yumi[3];

  assign v_o_w   = {if_b8.v_o, if_b4.v_o, if_b2.v_o, if_b1.v_o};
  assign ready_w = {if_b8.ready_o, if_b4.ready_o, if_b2.ready_o, if_b1.ready_o};
  assign res_w[0] = if_b1.result_o;
  assign res_w[1] = if_b2.result_o;
  assign res_w[2] = if_b4.result_o;
  assign res_w[3] = if_b8.result_o;

  gf_mult_seq #(.LANES(4), .BITS_PER_CYCLE(1)) u_b1 (.clk_i(clk), .reset_i(rst), .bus(if_b1));
  gf_mult_seq #(.LANES(4), .BITS_PER_CYCLE(2)) u_b2 (.clk_i(clk), .reset_i(rst), .bus(if_b2));
  gf_mult_seq #(.LANES(4), .BITS_PER_CYCLE(4)) u_b4 (.clk_i(clk), .reset_i(rst), .bus(if_b4));
  gf_mult_seq #(.LANES(4), .BITS_PER_CYCLE(8)) u_b8 (.clk_i(clk), .reset_i(rst), .bus(if_b8));

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s v_o b%0d", tag, 1 << d), {31'd0, v_o_w[d]}, 32'd0);
      check($sformatf("%s ready b%0d", tag, 1 << d), {31'd0, ready_w[d]}, 32'd1);
      check($sformatf("%s result b%0d", tag, 1 << d), res_w[d], 32'd0);
    end
  endtask

  // One operation on all instances; prod is the hand-computed per-lane product.
  task automatic run_op(input string tag, input logic [31:0] n1, input logic [31:0] n2,
                        input logic [31:0] prod, input logic clr);
    logic [31:0] exp;
    int lat [4];
    exp = prod;
`ifdef GF_MULT_ACC_EN
    exp = (clr ? 32'h0 : acc_m) ^ prod;
`endif
    @(negedge clk);
    check({tag, " ready before accept"}, {28'd0, ready_w}, 32'hF);
    v_i = 1'b1; num_1 = n1; num_2 = n2; acc_clr = clr;
    @(posedge clk); #1;
    // Keep offering junk while busy/done: must be ignored.
    num_1 = ~n1; num_2 = n2 ^ 32'h5A5A_A5A5; acc_clr = ~clr;
    lat = '{0, 0, 0, 0};
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 4; d++) begin
        if (v_o_w[d] && lat[d] == 0) lat[d] = cyc;
        if (lat[d] != 0) begin
          check($sformatf("%s hold b%0d c%0d", tag, 1 << d, cyc), res_w[d], exp);
          check($sformatf("%s v_o held b%0d c%0d", tag, 1 << d, cyc), {31'd0, v_o_w[d]}, 32'd1);
        end
        check($sformatf("%s ready low b%0d c%0d", tag, 1 << d, cyc), {31'd0, ready_w[d]}, 32'd0);
      end
    end
    v_i = 1'b0;
    for (int d = 0; d < 4; d++)
      check($sformatf("%s latency b%0d", tag, 1 << d), lat[d], 32'(8 >> d));
    yumi = 4'hF;
    @(posedge clk); #1;
    yumi = 4'h0;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s v_o after yumi b%0d", tag, 1 << d), {31'd0, v_o_w[d]}, 32'd0);
      check($sformatf("%s ready after yumi b%0d", tag, 1 << d), {31'd0, ready_w[d]}, 32'd1);
      check($sformatf("%s result kept b%0d", tag, 1 << d), res_w[d], exp);
    end
`ifdef GF_MULT_ACC_EN
    acc_m = exp;
`endif
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    v_i = 1'b0; num_1 = '0; num_2 = '0; acc_clr = 1'b1; yumi = 4'h0;
`ifdef GF_MULT_ACC_EN
    acc_m = '0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk) rst = 1'b0;

    // driver: directed vectors (lane 3 .. lane 0)
    run_op("basic", 32'h5799_0701, 32'h8302_0802, 32'hC129_3802, 1'b1);
    run_op("mix",   32'h0813_00FF, 32'h0757_5A01, 32'h38FE_00FF, 1'b1);
    run_op("zero",  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1);
    run_op("full",  32'hFF01_0257, 32'hFF01_0213, 32'h1301_04FE, 1'b1);

    // Reset during BUSY: outputs must return to reset values without a clock edge.
    @(negedge clk);
    v_i = 1'b1; num_1 = 32'h5713_0101; num_2 = 32'h1357_0202;
    @(posedge clk); #1 v_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_state("midbusy reset");
    @(negedge clk) rst = 1'b0;
`ifdef GF_MULT_ACC_EN
    acc_m = '0;
`endif
    run_op("after reset", 32'h5757_5757, 32'h1313_1313, 32'hFEFE_FEFE, 1'b0);

`ifdef GF_MULT_ACC_EN
    run_op("acc op1", 32'h5757_5757, 32'h0202_0202, 32'hAEAE_AEAE, 1'b1);
    run_op("acc op2", 32'h5757_5757, 32'h0303_0303, 32'hF9F9_F9F9, 1'b0);
    check("acc op2 sum", acc_m, 32'h5757_5757);
    run_op("acc op3", 32'h0101_0101, 32'h0101_0101, 32'h0101_0101, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
